mem_line_responder: RTL and testbench
=====================================

# mem_line_responder

Line-granular backing data memory that answers the data cache's memory-side request/acknowledge protocol. Accepts one 256-bit line read or write at a time, waits a programmable fixed latency, then pulses an acknowledge with read data. Sits on the far side of the cache-to-memory bus, opposite the dcache controller in the testbench/top level.

## Interface
- LATENCY, 10: cycles from request acceptance to the acknowledge cycle; legal range 1..255.
- DEPTH_LOG2, 9: log2 of the number of 256-bit lines; 9 gives 512 lines (16 KiB).
- clk_i  input  1  single clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- mem_enable_i  input  1  request valid; held by the requester until it sees mem_ack_o.
- mem_write_i  input  1  1 = line write, 0 = line read; sampled with the request.
- mem_addr_i  input  32  byte address; bits [4:0] ignored, index = bits [DEPTH_LOG2+4:5], upper bits ignored.
- mem_data_i  input  256  write line data; sampled with the request.
- mem_ack_o  output  1  one-cycle completion pulse.
- mem_data_o  output  256  read line data, valid only during mem_ack_o of a read.
- busy_o  output  1  high while a request is outstanding (states WAIT and ACK).

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if mem_enable_i = 1 at a rising edge, latch write flag, line index, and write data; clear the counter to 0; go to WAIT. Otherwise stay.
- WAIT: counter increments each edge. When the counter reaches LATENCY-1, go to ACK on that edge. For LATENCY = 1, WAIT lasts one cycle.
- ACK: mem_ack_o = 1 for exactly this cycle.
  - Read: mem_data_o = line[latched index].
  - Write: line[latched index] <= latched data at the edge ending ACK; mem_data_o = 0.
  - Always return to IDLE.
  - mem_enable_i is ignored during ACK.
- Requester-side changes after acceptance (addr/data/write) have no effect; latched values govern.
- If mem_enable_i is still high in the IDLE cycle following ACK, it is a new request and is accepted.
- Index wrap: addresses beyond the array alias modulo 2^DEPTH_LOG2 lines. There is no error response.
- Array contents are not reset. The bench preloads via hierarchical access or $readmemh on the array.
- Read-after-write to the same line across back-to-back requests returns the new data, since the write commits before the next acceptance is possible.

## Timing
- Reset values (asserted asynchronously while rst_i = 0): state IDLE, counter 0, mem_ack_o 0, mem_data_o 0, busy_o 0.
- Acceptance edge = edge 0. busy_o is high from after edge 0 through the ACK cycle.
- mem_ack_o is high strictly between edge LATENCY and edge LATENCY+1. mem_data_o is registered and valid in that same window.
- Write commit occurs at edge LATENCY+1.
- Minimum request-to-request spacing is LATENCY+2 edges (accept, LATENCY cycles, back in IDLE).
- mem_ack_o is never high in two consecutive cycles.
- Reset mid-operation (in WAIT or ACK): abort immediately, no write committed, mem_ack_o drops asynchronously, return to IDLE.
- Enable deasserted while in WAIT: the request still completes and mem_ack_o still pulses. The protocol forbids withdrawal; the responder does not check for it.

## Test plan
- Reset: hold rst_i = 0 for 3 cycles with mem_enable_i = 1 -> mem_ack_o = 0, busy_o = 0, mem_data_o = 0 throughout; no acceptance until after release.
- Read latency: preload line 4 = {8{32'hDEADBEEF}}, request read addr 0x0000_0080, LATENCY = 10 -> mem_ack_o high exactly in the cycle after edge 10, mem_data_o = preloaded line, busy_o high for 11 cycles.
- Write then read: write addr 0x0000_0100, data {8{32'h12345678}}, hold enable until ack, drop, then read same addr -> second ack returns {8{32'h12345678}}; addr 0x0000_011F reads the same line.
- Back-to-back: keep mem_enable_i high continuously across two reads (0x40, 0x60) -> two single-cycle acks separated by LATENCY+1 idle-to-ack cycles; no double ack.
- Reset mid-write: start write 0x200 = all-ones, pull rst_i low at cycle 5 of WAIT, release, read 0x200 -> original preloaded value (0), ack after LATENCY.
- Wrap/LATENCY = 1: instantiate LATENCY = 1, DEPTH_LOG2 = 4; write addr 0x0000_0000, read addr 0x0000_0200 -> alias returns written data; ack in the second cycle after acceptance.

Source files
------------

// File: rtl/mem_line_responder.sv
// mem_line_responder: line-granular backing memory for the data cache's
// memory-side request/acknowledge bus. One 256-bit line read or write is
// accepted at a time, held for a fixed LATENCY, then acknowledged for a
// single cycle. Read data is registered and valid only during the ack.
module mem_line_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         mem_enable_i,
    input  logic         mem_write_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [255:0] mem_data_i,
    output logic         mem_ack_o,
    output logic [255:0] mem_data_o,
    output logic         busy_o
);

    localparam int LINES = 1 << DEPTH_LOG2;

    // The counter is 8 bits wide because LATENCY is limited to 1..255.
    localparam logic [7:0] LAST_COUNT = 8'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]            state;
    logic [7:0]            count;
    logic                  write_q;
    logic [DEPTH_LOG2-1:0] index_q;
    logic [255:0]          wdata_q;
    logic [255:0]          rdata_q;
    logic [255:0]          lines [LINES];

    // Byte offset and bits above the array alias away; they are dropped here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:DEPTH_LOG2+5], mem_addr_i[4:0]};

    wire accept    = (state == ST_IDLE) && mem_enable_i;
    wire last_wait = (state == ST_WAIT) && (count == LAST_COUNT);

    // Request sequencing: accept in IDLE, count out the latency, ack once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        state <= ST_WAIT;
                        count <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (count == LAST_COUNT) begin
                        state <= ST_ACK;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the request at acceptance; later requester changes are ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= mem_write_i;
            index_q <= mem_addr_i[DEPTH_LOG2+4:5];
            wdata_q <= mem_data_i;
        end
    end

    // Register read data on the edge entering ACK; zero at every other time.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (last_wait && !write_q) begin
            rdata_q <= lines[index_q];
        end else begin
            rdata_q <= '0;
        end
    end

    // Commit a write on the edge that ends ACK; a reset in ACK suppresses it.
    always_ff @(posedge clk_i) begin
        if (rst_i && (state == ST_ACK) && write_q) begin
            lines[index_q] <= wdata_q;
        end
    end

    assign mem_ack_o  = (state == ST_ACK);
    assign busy_o     = (state != ST_IDLE);
    assign mem_data_o = rdata_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: drives two responders (LATENCY 10 / 512 lines and
// LATENCY 1 / 16 lines) with directed and random line traffic and checks
// every cycle against a transaction-level model of the memory.
module tb_mem_line_responder;

    localparam int LAT_A = 10;
    localparam int DL_A  = 9;
    localparam int LAT_B = 1;
    localparam int DL_B  = 4;

    localparam logic [255:0] BEEF_LINE = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_LINE  = {8{32'h12345678}};
    localparam logic [255:0] ONES_LINE = {256{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    logic en [2];
    logic wr [2];
    logic [31:0]  addr [2];
    logic [255:0] wdata [2];
    logic ack_a, ack_b, busy_a, busy_b;
    logic [255:0] rd_a, rd_b;

    int tests = 0;
    int fails = 0;
    int n = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    mem_line_responder #(.LATENCY(LAT_A), .DEPTH_LOG2(DL_A)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .mem_enable_i(en[0]), .mem_write_i(wr[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wdata[0]),
        .mem_ack_o(ack_a), .mem_data_o(rd_a), .busy_o(busy_a)
    );

    mem_line_responder #(.LATENCY(LAT_B), .DEPTH_LOG2(DL_B)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .mem_enable_i(en[1]), .mem_write_i(wr[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wdata[1]),
        .mem_ack_o(ack_b), .mem_data_o(rd_b), .busy_o(busy_b)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int dl_of(input int k);
        return (k == 0) ? DL_A : DL_B;
    endfunction

    function automatic logic ack_of(input int k);
        return (k == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [255:0] rd_of(input int k);
        return (k == 0) ? rd_a : rd_b;
    endfunction

    function automatic int line_of(input int k, input logic [31:0] a);
        return int'(a / 32) % (1 << dl_of(k));
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: a request taken at edge t is acknowledged in the
    // cycle after edge t+LAT, and a write lands in memory at edge t+LAT+1.
    bit           m_out   [2];
    bit           m_wr    [2];
    int           m_acc   [2];
    int           m_idx   [2];
    logic [255:0] m_data  [2];
    logic [255:0] m_mem   [2][512];
    bit           m_valid [2][512];

    // Model advance at each rising edge.
    always @(posedge clk) begin
        n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_out[k] = 1'b0;
            end else if (m_out[k]) begin
                if (n == m_acc[k] + lat_of(k) + 1) begin
                    if (m_wr[k]) begin
                        m_mem[k][m_idx[k]]   = m_data[k];
                        m_valid[k][m_idx[k]] = 1'b1;
                    end
                    m_out[k] = 1'b0;
                end
            end else if (en[k]) begin
                m_out[k]  = 1'b1;
                m_acc[k]  = n;
                m_wr[k]   = wr[k];
                m_idx[k]  = line_of(k, addr[k]);
                m_data[k] = wdata[k];
            end
        end
    end

    // Per-cycle comparison of both responders against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic exp_ack;
            exp_ack = m_out[k] && (n == m_acc[k] + lat_of(k));
            checkOutput($sformatf("ack[%0d] n=%0d", k, n), 256'(ack_of(k)), 256'(exp_ack));
            checkOutput($sformatf("busy[%0d] n=%0d", k, n), 256'(busy_of(k)), 256'(m_out[k]));
            if (exp_ack && !m_wr[k]) begin
                if (m_valid[k][m_idx[k]])
                    checkOutput($sformatf("rdata[%0d] n=%0d", k, n), rd_of(k), m_mem[k][m_idx[k]]);
            end else begin
                checkOutput($sformatf("rdata_zero[%0d] n=%0d", k, n), rd_of(k), 256'(0));
            end
        end
    end

    // One request from an idle responder; returns acceptance/ack cycle numbers.
    task automatic applyStimulus(input int k, input bit w, input logic [31:0] a,
                                 input logic [255:0] d, input bit scramble, input bit drop_early,
                                 output int acc_n, output int ack_n, output int busy_cnt,
                                 output logic [255:0] got);
        bit done;
        @(negedge clk);
        #1;
        en[k] = 1'b1;
        wr[k] = w;
        addr[k] = a;
        wdata[k] = d;
        done = 1'b0;
        busy_cnt = 0;
        acc_n = -1;
        ack_n = -1;
        got = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (acc_n < 0) acc_n = n;
            if (busy_of(k)) busy_cnt++;
            if (ack_of(k)) begin
                done = 1'b1;
                ack_n = n;
                got = rd_of(k);
            end else if (c == 0) begin
                #1;
                if (scramble) begin
                    wr[k] = ~wr[k];
                    addr[k] = $urandom;
                    wdata[k] = rand256();
                end
                if (drop_early) en[k] = 1'b0;
            end
        end
        #1;
        en[k] = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL ack_timeout[%0d]: got no ack expected ack within 300 cycles", k);
        end
    endtask

    // Wait for the next ack on responder k with a cycle bound.
    task automatic wait_ack(input int k, output int ack_n, output logic [255:0] got);
        bit done;
        done = 1'b0;
        ack_n = -1;
        got = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (ack_of(k)) begin
                done = 1'b1;
                ack_n = n;
                got = rd_of(k);
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL wait_ack[%0d]: got no ack expected ack within 300 cycles", k);
        end
    endtask

    // Safety net so the run always terminates.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int acc_n, ack_n, bc, a1, a2;
        logic [255:0] got;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b1;
            wr[k] = 1'b0;
            addr[k] = '0;
            wdata[k] = '0;
        end
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_ack_a", 256'(ack_a), 256'(0));
            checkOutput("reset_busy_a", 256'(busy_a), 256'(0));
            checkOutput("reset_data_a", rd_a, 256'(0));
        end
        #1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        rst_n = 1'b1;

        // Known contents for the lines used below.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b1, 32'(i * 32), rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
            applyStimulus(1, 1'b1, 32'(i * 32), rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        end
        applyStimulus(0, 1'b1, 32'h80, BEEF_LINE, 1'b0, 1'b0, acc_n, ack_n, bc, got);
        applyStimulus(0, 1'b1, 32'h200, 256'(0), 1'b0, 1'b0, acc_n, ack_n, bc, got);

        // Read latency and busy window.
        applyStimulus(0, 1'b0, 32'h80, rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("read_latency", 256'(ack_n - acc_n), 256'(10));
        checkOutput("read_busy_cycles", 256'(bc), 256'(11));
        checkOutput("read_data", got, BEEF_LINE);
        @(negedge clk);
        checkOutput("busy_after_ack", 256'(busy_a), 256'(0));

        // Write then read back, including a byte-offset alias.
        applyStimulus(0, 1'b1, 32'h100, PAT_LINE, 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("write_ack_data_zero", got, 256'(0));
        applyStimulus(0, 1'b0, 32'h100, rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("readback_100", got, PAT_LINE);
        applyStimulus(0, 1'b0, 32'h11F, rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("readback_11F", got, PAT_LINE);

        // Back-to-back reads with enable held continuously.
        applyStimulus(0, 1'b1, 32'h40, {8{32'h0000_0040}}, 1'b0, 1'b0, acc_n, ack_n, bc, got);
        applyStimulus(0, 1'b1, 32'h60, {8{32'h0000_0060}}, 1'b0, 1'b0, acc_n, ack_n, bc, got);
        @(negedge clk);
        #1;
        en[0] = 1'b1;
        wr[0] = 1'b0;
        addr[0] = 32'h40;
        wait_ack(0, a1, got);
        checkOutput("b2b_first_data", got, {8{32'h0000_0040}});
        #1;
        addr[0] = 32'h60;
        wait_ack(0, a2, got);
        checkOutput("b2b_second_data", got, {8{32'h0000_0060}});
        checkOutput("b2b_ack_spacing", 256'(a2 - a1), 256'(12));
        #1;
        en[0] = 1'b0;

        // Reset in the middle of a write must not commit it.
        @(negedge clk);
        @(negedge clk);
        #1;
        en[0] = 1'b1;
        wr[0] = 1'b1;
        addr[0] = 32'h200;
        wdata[0] = ONES_LINE;
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 256'(busy_a), 256'(0));
        checkOutput("midreset_ack", 256'(ack_a), 256'(0));
        en[0] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 32'h200, rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("midreset_readback", got, 256'(0));
        checkOutput("midreset_latency", 256'(ack_n - acc_n), 256'(10));

        // LATENCY 1 with a 16-line array: index aliasing.
        applyStimulus(1, 1'b1, 32'h0, PAT_LINE, 1'b0, 1'b0, acc_n, ack_n, bc, got);
        applyStimulus(1, 1'b0, 32'h200, rand256(), 1'b0, 1'b0, acc_n, ack_n, bc, got);
        checkOutput("alias_data", got, PAT_LINE);
        checkOutput("alias_latency", 256'(ack_n - acc_n), 256'(1));
        checkOutput("alias_busy_cycles", 256'(bc), 256'(2));

        // Random traffic with post-acceptance scrambling and early enable drop.
        for (int t = 0; t < 150; t++) begin
            int k;
            int idx;
            logic [31:0] mask, a;
            k = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            mask = 32'(((1 << dl_of(k)) - 1) << 5);
            a = ($urandom & ~mask) | 32'(idx << 5);
            applyStimulus(k, 1'($urandom_range(0, 1)), a, rand256(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          acc_n, ack_n, bc, got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
